// File: rtl/req_fifo_mc_pkg.sv
// Shared types and width helpers for the multi-channel request FIFO.
package req_fifo_mc_pkg;

    localparam int MAX_CH = 8;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  tag;
        logic [15:0] addr;
    } req_pkt_type;

    localparam int PKT_W = $bits(req_pkt_type);

    // Channel index needs at least one bit even with a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_fifo_mc_if.sv
// Push/pop bundle between producers/consumer (master) and the FIFO block (slave).
interface req_fifo_mc_if #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8
);
    import req_fifo_mc_pkg::*;

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]             wr_en;
    req_pkt_type [NUM_CH-1:0]      wr_req;
    logic [NUM_CH-1:0]             full;
    logic [NUM_CH-1:0]             almost_full;
    logic [NUM_CH-1:0][LVL_W-1:0]  level;
    logic                          out_valid;
    logic                          out_ready;
    req_pkt_type                   out_req;
    logic [CH_W-1:0]               out_ch;
    logic                          overflow_err;

    modport master (
        output wr_en, wr_req, out_ready,
        input  full, almost_full, level, out_valid, out_req, out_ch, overflow_err
    );

    modport slave (
        input  wr_en, wr_req, out_ready,
        output full, almost_full, level, out_valid, out_req, out_ch, overflow_err
    );

endinterface

// File: rtl/req_fifo_ch.sv
// Single-channel show-ahead FIFO with occupancy count and full/almost-full flags.
module req_fifo_ch
    import req_fifo_mc_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  req_pkt_type      push_pkt,
    input  logic             pop,
    output req_pkt_type      head,
    output logic             full,
    output logic             almost_full,
    output logic             avail,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    req_pkt_type      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             wr_acc;

    // A push to a full channel is dropped even if this channel pops in the same cycle.
    assign wr_acc = push && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= push_pkt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign full        = (cnt == LVL_W'(DEPTH));
    assign almost_full = (cnt >= LVL_W'(AF_LEVEL));
    assign avail       = (cnt != '0);
    assign level       = cnt;
    assign head        = mem[rd_ptr];
    assign overflow    = push && full;

endmodule

// File: rtl/req_fifo_mc.sv
// NUM_CH request FIFOs drained round-robin through one show-ahead output port.
module req_fifo_mc
    import req_fifo_mc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input logic          clk,
    input logic          rst,
    req_fifo_mc_if.slave bus
);
    localparam int CH_W  = ch_w(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]            avail, pop, ovf, full, afull;
    logic [NUM_CH-1:0][LVL_W-1:0] lvl;
    req_pkt_type [NUM_CH-1:0]     head;
    logic [CH_W-1:0]              rr_ptr, rr_sel, sel, hold_ch;
    logic                         rr_found, hold_vld, any_vld, out_vld, do_pop, ovf_err;
    int                           idx;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        req_fifo_ch #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .push        (bus.wr_en[c]),
            .push_pkt    (bus.wr_req[c]),
            .pop         (pop[c]),
            .head        (head[c]),
            .full        (full[c]),
            .almost_full (afull[c]),
            .avail       (avail[c]),
            .level       (lvl[c]),
            .overflow    (ovf[c])
        );
        assign pop[c] = do_pop && (sel == CH_W'(c));
    end

    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        idx      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!rr_found && avail[idx]) begin
                rr_found = 1'b1;
                rr_sel   = CH_W'(idx);
            end
        end
    end

    // A stalled grant is latched so pushes to other channels cannot steal the output.
    assign sel     = hold_vld ? hold_ch : rr_sel;
    assign any_vld = rr_found;
    assign out_vld = any_vld && !rst;
    assign do_pop  = out_vld && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            hold_vld <= 1'b0;
            hold_ch  <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (|ovf) ovf_err <= 1'b1;
            if (do_pop) rr_ptr <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
            hold_vld <= any_vld && !bus.out_ready;
            hold_ch  <= sel;
        end
    end

    assign bus.full         = rst ? '0 : full;
    assign bus.almost_full  = rst ? '0 : afull;
    assign bus.level        = rst ? '0 : lvl;
    assign bus.out_valid    = out_vld;
    assign bus.out_ch       = out_vld ? sel : '0;
    assign bus.out_req      = out_vld ? head[sel] : '0;
    assign bus.overflow_err = ovf_err && !rst;

endmodule

// File: doc/req_fifo_mc.md
REQ_FIFO_MC -- requirements
Module: req_fifo_mc

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent request channels (1..8).
REQ-002 Parameter DEPTH, default 8, SHALL set the entries per channel (power of 2, >=2).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, SHALL set the almost-full occupancy threshold (1..DEPTH-1).
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 wr_en  input  NUM_CH  SHALL be the per-channel push strobe.
REQ-007 wr_req  input  NUM_CH x req_pkt_type  SHALL be the per-channel push packet.
REQ-008 full  output  NUM_CH  SHALL be high when that channel's count == DEPTH.
REQ-009 almost_full  output  NUM_CH  SHALL be high when that channel's count >= AF_LEVEL.
REQ-010 level  output  NUM_CH x clog2(DEPTH+1)  SHALL be each channel's current occupancy.
REQ-011 out_valid  output  1  SHALL be high when any channel is non-empty.
REQ-012 out_ready  input  1  SHALL be the consumer accept strobe.
REQ-013 out_req  output  req_pkt_type  SHALL be the head packet of the selected channel, all-zero when out_valid is low.
REQ-014 out_ch  output  max(1,clog2(NUM_CH))  SHALL be the selected channel index, zero when out_valid is low.
REQ-015 overflow_err  output  1  SHALL be a sticky flag set by any push to a full channel.

Function
REQ-016 Push SHALL be accepted on channel c when wr_en[c] && !full[c]; the packet is stored at wr_ptr[c] and wr_ptr[c] increments modulo DEPTH.
REQ-017 Push to a full channel SHALL be dropped, leave FIFO state unchanged, and set overflow_err; this applies even when the same channel pops that cycle.
REQ-018 Pop SHALL occur on the selected channel when out_valid && out_ready; its rd_ptr increments modulo DEPTH.
REQ-019 Simultaneous accepted push and pop on one channel SHALL leave its count unchanged and both pointers advanced.
REQ-020 Count SHALL increment on push-only and decrement on pop-only; it never underflows, because pop requires out_valid.
REQ-021 Output SHALL be show-ahead: a packet pushed into an empty channel at edge N is visible on out_req after edge N (no same-cycle bypass).
REQ-022 Selection SHALL be round-robin: the first non-empty channel at or after rr_ptr, wrapping at NUM_CH.
REQ-023 rr_ptr SHALL load (granted channel + 1) mod NUM_CH on every pop and hold otherwise.
REQ-024 While out_valid && !out_ready, out_ch and out_req SHALL remain stable, even if other channels receive pushes.
REQ-025 All outputs except the stored packet data SHALL be derived from registered counts and pointers; there is no combinational path from wr_en to out_valid.
REQ-026 With NUM_CH=1 the block SHALL behave as a single FIFO with out_ch tied to 0.

Reset
REQ-027 Reset SHALL clear all pointers, counts, rr_ptr and overflow_err to 0 and SHALL zero all storage.
REQ-028 During and after reset, outputs SHALL read full=0, almost_full=0, level=0, out_valid=0, out_req='0 and out_ch=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored packets and ignore wr_en and out_ready in that cycle.

Structure
REQ-030 req_pkt_type SHALL come from the shared package, together with any channel-index width constants.
REQ-031 A sub-module req_fifo_ch (single-channel FIFO with count, full, almost_full and level) SHALL be instantiated NUM_CH times; the round-robin selector lives in req_fifo_mc.

Verification
REQ-032 Push ch0 with 8 packets (DEPTH=8) -> full[0]=1 after the 8th push, almost_full[0]=1 after the 6th, level[0]=8; a 9th push sets overflow_err=1 and leaves level[0]=8.
REQ-033 Push one packet each to ch0..ch3 in the same cycle, then hold out_ready=1 -> out_ch sequence is 0,1,2,3 and out_valid drops after 4 pops.
REQ-034 Hold out_ready=0 with ch2 selected while pushing ch0 -> out_ch stays 2 and out_req is unchanged until the accept.
REQ-035 Full ch1: push and pop ch1 in the same cycle -> the push is dropped, overflow_err=1, level[1]=7. Then at level 4, push and pop together -> level stays 4 and FIFO order is preserved.
REQ-036 Wrap: push and pop 20 packets through ch3 -> output order matches input order across pointer wrap.
REQ-037 Assert rst with 3 channels partly filled -> the next cycle shows out_valid=0, all level=0 and overflow_err=0.
